gmii_tx_arbiter_hcp: RTL and testbench

- Shares one host-side GMII transmit path between two frame requesters: the TSN chip egress and a local management/PTP injector.
- Requesters raise req and wait for gnt before starting a frame. The arbiter forwards the granted stream with one registered stage of latency.
- Enforces inter-frame gap, start timeout and maximum frame length, and keeps per-port frame and error counters.
- Sits in the HCP GMII adapter, ahead of the transmit CRC/length control stage.

---
 rtl/gmii_tx_arbiter_hcp.sv | 186 ++++++++++++++++++
 tb/tb_gmii_tx_arbiter_hcp.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_arbiter_hcp.sv
// gmii_tx_arbiter_hcp: two-requester GMII transmit arbiter for the HCP adapter.
// Grants one of two frame sources (port 0 = TSN chip egress, port 1 = mgmt/PTP
// injector), forwards the granted stream with one registered stage, and enforces
// start timeout, maximum frame length and inter-frame gap.
//
// Ports:
//   clk, rst                      GMII tx clock, synchronous active-high reset
//   req0/gnt0, gmii_*0            port 0 request/grant and GMII input
//   req1/gnt1, gmii_*1            port 1 request/grant and GMII input
//   gmii_tx_en/er/txd             arbitrated GMII output (registered)
//   frm_cnt0/1                    completed frames per port, saturating
//   err_cnt                       start timeouts plus truncations, saturating
module gmii_tx_arbiter_hcp #(
    parameter int unsigned IFG_CYCLES    = 12,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned MAX_BEATS     = 1530
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    output logic        gnt0,
    input  logic        gmii_dv0,
    input  logic        gmii_er0,
    input  logic [7:0]  gmii_data0,
    input  logic        req1,
    output logic        gnt1,
    input  logic        gmii_dv1,
    input  logic        gmii_er1,
    input  logic [7:0]  gmii_data1,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [7:0]  gmii_txd,
    output logic [15:0] frm_cnt0,
    output logic [15:0] frm_cnt1,
    output logic [15:0] err_cnt
);

    localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);
    localparam int unsigned WAIT_W = $clog2(START_TIMEOUT + 1);
    localparam int unsigned IFG_W  = $clog2(IFG_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_WAIT,
        XMIT,
        DRAIN,
        IFG
    } state_t;

    state_t              state;
    logic                sel;   // currently granted port
    logic                ptr;   // port favoured on a simultaneous request
    logic [BEAT_W-1:0]   beat_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [IFG_W-1:0]    ifg_cnt;

    // Granted port's inputs; the other port is never looked at.
    logic       sel_req;
    logic       sel_dv;
    logic       sel_er;
    logic [7:0] sel_data;

    assign sel_req  = sel ? req1       : req0;
    assign sel_dv   = sel ? gmii_dv1   : gmii_dv0;
    assign sel_er   = sel ? gmii_er1   : gmii_er0;
    assign sel_data = sel ? gmii_data1 : gmii_data0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Arbitration FSM with registered grant, datapath and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 1'b0;
            ptr        <= 1'b0;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            ifg_cnt    <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            gmii_txd   <= 8'd0;
            frm_cnt0   <= 16'd0;
            frm_cnt1   <= 16'd0;
            err_cnt    <= 16'd0;
        end else begin
            // Output idles unless a beat is forwarded below.
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            gmii_txd   <= 8'd0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        if (req0 && req1) begin
                            sel  <= ptr;
                            gnt0 <= ~ptr;
                            gnt1 <= ptr;
                            ptr  <= ~ptr;
                        end else begin
                            sel  <= req1;
                            gnt0 <= req0;
                            gnt1 <= req1;
                        end
                        wait_cnt <= '0;
                        state    <= GRANT_WAIT;
                    end
                end

                GRANT_WAIT: begin
                    if (sel_dv) begin
                        gmii_tx_en <= 1'b1;
                        gmii_tx_er <= sel_er;
                        gmii_txd   <= sel_data;
                        beat_cnt   <= BEAT_W'(1);
                        state      <= XMIT;
                    end else if (!sel_req) begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        state <= IDLE;
                    end else if (wait_cnt == WAIT_W'(START_TIMEOUT - 1)) begin
                        // Stalled requester: release and let the other side go first.
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        err_cnt <= sat_inc(err_cnt);
                        ptr     <= ~sel;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                XMIT: begin
                    if (sel_dv) begin
                        gmii_tx_en <= 1'b1;
                        gmii_txd   <= sel_data;
                        if (beat_cnt == BEAT_W'(MAX_BEATS - 1)) begin
                            // Oversize frame: poison the last beat so downstream drops it.
                            gmii_tx_er <= 1'b1;
                            err_cnt    <= sat_inc(err_cnt);
                            state      <= DRAIN;
                        end else begin
                            gmii_tx_er <= sel_er;
                            beat_cnt   <= beat_cnt + BEAT_W'(1);
                        end
                    end else begin
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        ifg_cnt <= '0;
                        state   <= IFG;
                        if (sel) frm_cnt1 <= sat_inc(frm_cnt1);
                        else     frm_cnt0 <= sat_inc(frm_cnt0);
                    end
                end

                DRAIN: begin
                    // Swallow the rest of the oversize frame, keeping the grant.
                    if (!sel_dv) begin
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        ifg_cnt <= '0;
                        state   <= IFG;
                    end
                end

                IFG: begin
                    if (ifg_cnt == IFG_W'(IFG_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt + IFG_W'(1);
                    end
                end

                default: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_arbiter_hcp.sv
// Testbench for gmii_tx_arbiter_hcp: stimulus pushes expected output beats
// (data, er, output cycle) into a queue; a negedge monitor pops and compares.
module tb_gmii_tx_arbiter_hcp;

    localparam int unsigned IFG_CYCLES    = 12;
    localparam int unsigned START_TIMEOUT = 16;
    localparam int unsigned MAX_BEATS     = 1530;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, gnt0, gmii_dv0, gmii_er0;
    logic [7:0]  gmii_data0;
    logic        req1, gnt1, gmii_dv1, gmii_er1;
    logic [7:0]  gmii_data1;
    logic        gmii_tx_en, gmii_tx_er;
    logic [7:0]  gmii_txd;
    logic [15:0] frm_cnt0, frm_cnt1, err_cnt;

    gmii_tx_arbiter_hcp #(
        .IFG_CYCLES   (IFG_CYCLES),
        .START_TIMEOUT(START_TIMEOUT),
        .MAX_BEATS    (MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .gnt0      (gnt0),
        .gmii_dv0  (gmii_dv0),
        .gmii_er0  (gmii_er0),
        .gmii_data0(gmii_data0),
        .req1      (req1),
        .gnt1      (gnt1),
        .gmii_dv1  (gmii_dv1),
        .gmii_er1  (gmii_er1),
        .gmii_data1(gmii_data1),
        .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er),
        .gmii_txd  (gmii_txd),
        .frm_cnt0  (frm_cnt0),
        .frm_cnt1  (frm_cnt1),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        er;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          gnt_log[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int unsigned tx_beats = 0;
    int unsigned gap = 0;
    bit          seen_frame = 0;
    bit          prev_en = 0;
    bit          prev_g0 = 0;
    bit          prev_g1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pop, idle-zero, IFG gap and grant exclusivity.
    always @(negedge clk) begin
        check("gnt_exclusive", longint'(gnt0 & gnt1), 0);
        if (gnt0 && !prev_g0) gnt_log.push_back(0);
        if (gnt1 && !prev_g1) gnt_log.push_back(1);
        if (gmii_tx_en) begin
            tx_beats++;
            if (!prev_en && seen_frame)
                check("ifg_gap_ok", longint'(gap >= IFG_CYCLES + 2), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_tx_beat", longint'(gmii_txd), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tx_beat", longint'({gmii_tx_er, gmii_txd}), longint'({e.er, e.d}));
                check("tx_latency", longint'(cyc), longint'(e.cyc));
            end
            seen_frame = 1;
            gap = 0;
        end else begin
            gap++;
            check("idle_zero", longint'({gmii_tx_er, gmii_txd}), 0);
        end
        if (rst) begin
            seen_frame = 0;
            gap = 0;
        end
        prev_en = gmii_tx_en;
        prev_g0 = gnt0;
        prev_g1 = gnt1;
    end

    function automatic logic get_gnt(input int p);
        return (p == 0) ? gnt0 : gnt1;
    endfunction

    task automatic set_req(input int p, input logic v);
        if (p == 0) req0 = v; else req1 = v;
    endtask

    task automatic drive(input int p, input logic dv, input logic er, input logic [7:0] d);
        if (p == 0) begin gmii_dv0 = dv; gmii_er0 = er; gmii_data0 = d; end
        else        begin gmii_dv1 = dv; gmii_er1 = er; gmii_data1 = d; end
    endtask

    // Bounded wait for a grant; an expired bound is reported as a failed comparison.
    task automatic wait_gnt(input int p, input int max_cyc, input string name);
        for (int i = 0; i < max_cyc; i++) begin
            if (get_gnt(p)) break;
            tick();
        end
        check(name, longint'(get_gnt(p)), 1);
    endtask

    // Drive n beats; er_idx marks one beat with er; trunc>0 means only the first
    // trunc beats are forwarded, the last of them with er forced.
    task automatic send_frame(input int p, input int n, input int er_idx, input int trunc);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            logic       er;
            exp_t       e;
            d  = 8'((p * 128) + i * 3 + 1);
            er = (i == er_idx);
            drive(p, 1'b1, er, d);
            if (trunc == 0 || i < trunc) begin
                e.d   = d;
                e.er  = er | (i == trunc - 1);
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            tick();
        end
        drive(p, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        drive(0, 1'b0, 1'b0, 8'd0);
        drive(1, 1'b0, 1'b0, 8'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic rr_port(input int p);
        for (int f = 0; f < 2; f++) begin
            set_req(p, 1'b1);
            wait_gnt(p, 300, "rr_grant");
            send_frame(p, 64, -1, 0);
            tick();
        end
        set_req(p, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b0;
        int          hold;

        // Reset state
        do_reset();
        check("rst_tx_en", longint'(gmii_tx_en), 0);
        check("rst_tx_er", longint'(gmii_tx_er), 0);
        check("rst_txd", longint'(gmii_txd), 0);
        check("rst_gnt", longint'({gnt1, gnt0}), 0);
        check("rst_cnts", longint'({frm_cnt0, frm_cnt1, err_cnt}), 0);

        // Basic forward: 72-beat frame on port 0 with one er beat
        b0 = tx_beats;
        req0 = 1'b1;
        wait_gnt(0, 4, "basic_grant");
        send_frame(0, 72, 10, 0);
        req0 = 1'b0;
        tick();
        check("basic_gnt_fall", longint'(gnt0), 0);
        repeat (3) tick();
        check("basic_beats", longint'(tx_beats - b0), 72);
        check("basic_frm_cnt0", longint'(frm_cnt0), 1);
        check("basic_err_cnt", longint'(err_cnt), 0);
        check("basic_drained", longint'(exp_q.size()), 0);

        // Round-robin: both ports request continuously, two frames each
        do_reset();
        gnt_log.delete();
        fork
            rr_port(0);
            rr_port(1);
        join
        repeat (20) tick();
        check("rr_grant_count", longint'(gnt_log.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < gnt_log.size()) check("rr_grant_order", longint'(gnt_log[i]), longint'(i % 2));
        check("rr_frm_cnt0", longint'(frm_cnt0), 2);
        check("rr_frm_cnt1", longint'(frm_cnt1), 2);
        check("rr_drained", longint'(exp_q.size()), 0);

        // Start timeout on port 1 with port 0 pending
        b0 = tx_beats;
        req1 = 1'b1;
        wait_gnt(1, 4, "to_grant1");
        req0 = 1'b1;
        hold = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!gnt1) break;
            hold++;
        end
        check("to_gnt1_cycles", longint'(hold), longint'(START_TIMEOUT));
        check("to_err_cnt", longint'(err_cnt), 1);
        req1 = 1'b0;
        wait_gnt(0, 3, "to_grant0_next");
        req0 = 1'b0;
        tick();
        tick();
        check("to_gnt0_released", longint'(gnt0), 0);
        check("to_err_unchanged", longint'(err_cnt), 1);
        check("to_no_tx", longint'(tx_beats - b0), 0);

        // Reset mid-frame: counters are non-zero going in
        repeat (2) tick();
        req0 = 1'b1;
        wait_gnt(0, 4, "rstmid_grant");
        for (int i = 0; i < 30; i++) begin
            exp_t e;
            drive(0, 1'b1, 1'b0, 8'(i + 40));
            if (i == 29) begin
                rst = 1'b1;
            end else begin
                e.d = 8'(i + 40); e.er = 1'b0; e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            tick();
        end
        check("rstmid_out", longint'({gmii_tx_en, gmii_tx_er, gmii_txd}), 0);
        check("rstmid_gnt", longint'({gnt1, gnt0}), 0);
        check("rstmid_cnts", longint'({frm_cnt0, frm_cnt1, err_cnt}), 0);
        rst = 1'b0;
        req0 = 1'b0;
        drive(0, 1'b0, 1'b0, 8'd0);
        tick();
        req0 = 1'b1;
        req1 = 1'b1;
        wait_gnt(0, 3, "rstmid_port0_wins");
        check("rstmid_gnt1_low", longint'(gnt1), 0);
        req1 = 1'b0;
        send_frame(0, 8, -1, 0);
        req0 = 1'b0;
        repeat (16) tick();
        check("rstmid_frm_cnt0", longint'(frm_cnt0), 1);
        check("rstmid_drained", longint'(exp_q.size()), 0);

        // Truncation: 1600-beat frame on port 0
        do_reset();
        b0 = tx_beats;
        req0 = 1'b1;
        wait_gnt(0, 4, "trunc_grant");
        for (int i = 0; i < 1600; i++) begin
            logic [7:0] d;
            exp_t       e;
            d = 8'(i);
            drive(0, 1'b1, 1'b0, d);
            if (i < MAX_BEATS) begin
                e.d = d; e.er = (i == MAX_BEATS - 1); e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            tick();
        end
        check("trunc_gnt_held", longint'(gnt0), 1);
        drive(0, 1'b0, 1'b0, 8'd0);
        req0 = 1'b0;
        tick();
        check("trunc_gnt_fall", longint'(gnt0), 0);
        repeat (3) tick();
        check("trunc_beats", longint'(tx_beats - b0), longint'(MAX_BEATS));
        check("trunc_err_cnt", longint'(err_cnt), 1);
        check("trunc_frm_cnt0", longint'(frm_cnt0), 0);
        check("trunc_drained", longint'(exp_q.size()), 0);

        // Request withdrawal before any dv
        do_reset();
        req1 = 1'b1;
        wait_gnt(1, 4, "wd_grant1");
        tick();
        tick();
        req1 = 1'b0;
        tick();
        check("wd_gnt1_fall", longint'(gnt1), 0);
        req0 = 1'b1;
        wait_gnt(0, 2, "wd_grant0_fast");
        check("wd_err_cnt", longint'(err_cnt), 0);
        req0 = 1'b0;
        repeat (3) tick();
        check("wd_gnt0_released", longint'(gnt0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
